// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter (WB > mul/div <-> load round-robin) with a
// pending-destination scoreboard. Define RF_ARB_STARVE_GUARD_EN for starvation guard.
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        sb_set,
    input  logic [4:0]  sb_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_stall,
    output logic        wr_en,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    logic        prio_md_q;
    logic        prio_md_d;
    logic        md_sel;
    logic        lsu_sel;
    logic        md_gnt;
    logic        lsu_gnt;
    logic        wr_en_q;
    logic        wr_en_d;
    logic [4:0]  rd_addr_q;
    logic [4:0]  rd_addr_d;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;

    // prio_md_q set means md won less recently than lsu
    always_comb begin
        md_sel  = md_valid && (prio_md_q || !lsu_valid);
        lsu_sel = lsu_valid && !md_sel;
        md_gnt  = !wb_en && md_sel;
        lsu_gnt = !wb_en && lsu_sel;
    end

    assign md_ready  = md_gnt;
    assign lsu_ready = lsu_gnt;

    always_comb begin
        prio_md_d = prio_md_q;
        if (md_gnt) begin
            prio_md_d = 1'b0;
        end else if (lsu_gnt) begin
            prio_md_d = 1'b1;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        unique case (1'b1)
            wb_en: begin
                wr_en_d   = |wb_rd;
                rd_addr_d = wb_rd;
                rd_data_d = wb_data;
            end
            md_gnt: begin
                wr_en_d   = |md_rd;
                rd_addr_d = md_rd;
                rd_data_d = md_data;
            end
            lsu_gnt: begin
                wr_en_d   = |lsu_rd;
                rd_addr_d = lsu_rd;
                rd_data_d = lsu_data;
            end
            default: ;
        endcase
    end

    // set is applied after clear so a same-cycle reissue stays pending
    always_comb begin
        pend_d = pend_q;
        if (md_gnt) begin
            pend_d[md_rd] = 1'b0;
        end
        if (lsu_gnt) begin
            pend_d[lsu_rd] = 1'b0;
        end
        if (sb_set) begin
            pend_d[sb_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    assign rs1_busy = (|rs1_addr) && pend_q[rs1_addr];
    assign rs2_busy = (|rs2_addr) && pend_q[rs2_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_md_q <= 1'b1;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            pend_q    <= 32'd0;
        end else begin
            prio_md_q <= prio_md_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pend_q    <= pend_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

    logic [7:0] md_cnt_q;
    logic [7:0] md_cnt_d;
    logic [7:0] lsu_cnt_q;
    logic [7:0] lsu_cnt_d;
    logic       stall_q;
    logic       stall_d;
    logic       md_blk;
    logic       lsu_blk;

    always_comb begin
        md_blk    = md_valid && !md_gnt;
        lsu_blk   = lsu_valid && !lsu_gnt;
        md_cnt_d  = 8'd0;
        lsu_cnt_d = 8'd0;
        if (md_blk) begin
            md_cnt_d = (md_cnt_q == LIM) ? md_cnt_q : md_cnt_q + 8'd1;
        end
        if (lsu_blk) begin
            lsu_cnt_d = (lsu_cnt_q == LIM) ? lsu_cnt_q : lsu_cnt_q + 8'd1;
        end
        // hold the bubble request until every saturated requester is served
        stall_d = (md_blk && md_cnt_q == LIM) ||
                  (lsu_blk && lsu_cnt_q == LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q  <= 8'd0;
            lsu_cnt_q <= 8'd0;
            stall_q   <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            lsu_cnt_q <= lsu_cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign wb_stall = stall_q;
`else
    assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: directed cases, then random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_rf_wr_arbiter;

    localparam int LIMIT = 8;
    localparam int S_NONE = 0;
    localparam int S_MD = 1;
    localparam int S_LSU = 2;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_rd = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_stall;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    rf_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_rd(md_rd), .md_data(md_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_stall(wb_stall),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t expq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    logic [31:0] pend_m;
    int last_sec;
    int md_wait;
    int lsu_wait;
    bit stall_m;
    bit md_gr;
    bit lsu_gr;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        pend_m   = '0;
        last_sec = S_LSU;
        md_wait  = 0;
        lsu_wait = 0;
        stall_m  = 1'b0;
        md_gr    = 1'b0;
        lsu_gr   = 1'b0;
    endtask

    task automatic step();
        int win;
        bit md_blk;
        bit lsu_blk;
        bit nstall;
        @(negedge clk);
        win = S_NONE;
        if (!wb_en) begin
            if (md_valid && lsu_valid)
                win = (last_sec == S_MD) ? S_LSU : S_MD;
            else if (md_valid)
                win = S_MD;
            else if (lsu_valid)
                win = S_LSU;
        end
        md_gr  = (win == S_MD);
        lsu_gr = (win == S_LSU);
        chk("md_ready", md_ready, md_gr);
        chk("lsu_ready", lsu_ready, lsu_gr);
        chk("rs1_busy", rs1_busy, rs1_addr != 0 && pend_m[rs1_addr]);
        chk("rs2_busy", rs2_busy, rs2_addr != 0 && pend_m[rs2_addr]);
        chk("wb_stall", wb_stall, stall_m);
        if (wb_en) begin
            if (wb_rd != 0) expq.push_back('{cyc + 1, wb_rd, wb_data});
        end else if (md_gr) begin
            if (md_rd != 0) expq.push_back('{cyc + 1, md_rd, md_data});
            pend_m[md_rd] = 1'b0;
        end else if (lsu_gr) begin
            if (lsu_rd != 0) expq.push_back('{cyc + 1, lsu_rd, lsu_data});
            pend_m[lsu_rd] = 1'b0;
        end
        if (win != S_NONE) last_sec = win;
        if (sb_set && sb_rd != 0) pend_m[sb_rd] = 1'b1;
        md_blk  = md_valid && !md_gr;
        lsu_blk = lsu_valid && !lsu_gr;
        nstall = GUARD && ((md_blk && md_wait >= LIMIT) ||
                           (lsu_blk && lsu_wait >= LIMIT));
        md_wait  = md_blk ? md_wait + 1 : 0;
        lsu_wait = lsu_blk ? lsu_wait + 1 : 0;
        stall_m  = nstall;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_drive();
        if (!md_valid || md_gr) begin
            md_valid = ($urandom_range(0, 99) < 40);
            md_rd    = 5'($urandom_range(0, 31));
            md_data  = $urandom;
        end
        if (!lsu_valid || lsu_gr) begin
            lsu_valid = ($urandom_range(0, 99) < 40);
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_data  = $urandom;
        end
        wb_en    = !stall_m && ($urandom_range(0, 99) < 50);
        wb_rd    = 5'($urandom_range(0, 31));
        wb_data  = $urandom;
        sb_set   = ($urandom_range(0, 99) < 30);
        sb_rd    = 5'($urandom_range(0, 31));
        rs1_addr = ($urandom_range(0, 1) == 1) ? md_rd : 5'($urandom_range(0, 31));
        rs2_addr = ($urandom_range(0, 1) == 1) ? lsu_rd : 5'($urandom_range(0, 31));
    endtask

    // write-port monitor
    always @(negedge clk) begin
        if (rst_n) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL wr_missed exp_rd=%0d act_wr_en=0 cyc=%0d",
                         expq[0].rd, cyc);
                void'(expq.pop_front());
            end
            if (wr_en) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexp act_rd=%0d exp_wr_en=0 cyc=%0d",
                             rd_addr, cyc);
                end else begin
                    chk("wr_addr", rd_addr, expq[0].rd);
                    chk("wr_data", rd_data, expq[0].data);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_md_ready", md_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // md and lsu contend: md first after reset, then lsu
        md_valid = 1; md_rd = 3; md_data = 32'hA0A0_0003;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hB0B0_0004;
        step();
        chk("rr_first_addr", rd_addr, 3);
        md_valid = 0;
        step();
        chk("rr_second_addr", rd_addr, 4);
        lsu_valid = 0;

        // wb beats a pending md
        wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        md_valid = 1; md_rd = 9; md_data = 32'h0000_1234;
        step();
        chk("wb_win_en", wr_en, 1);
        chk("wb_win_addr", rd_addr, 5);
        chk("wb_win_data", rd_data, 32'hDEADBEEF);
        wb_en = 0;
        step();
        md_valid = 0;

        // scoreboard set / clear on x7
        rs1_addr = 7; sb_set = 1; sb_rd = 7;
        step();
        sb_set = 0;
        chk("sb_busy", rs1_busy, 1);
        step();
        step();
        md_valid = 1; md_rd = 7; md_data = 32'h7777_0007;
        step();
        md_valid = 0;
        chk("sb_clear", rs1_busy, 0);
        step();
        // set and clear the same cycle: set wins
        sb_set = 1; sb_rd = 7;
        step();
        md_valid = 1; md_rd = 7; md_data = 32'h7777_1007;
        step();
        sb_set = 0; md_valid = 0;
        chk("setclr_busy", rs1_busy, 1);
        step();
        md_valid = 1;
        step();
        md_valid = 0;
        step();

        // x0 load: handshake completes, no write, no pending
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF_FFFF;
        rs1_addr = 0; sb_set = 1; sb_rd = 0;
        step();
        lsu_valid = 0; sb_set = 0;
        chk("x0_no_wr", wr_en, 0);
        step();

        // starvation under continuous writeback
        md_valid = 1; md_rd = 12; md_data = 32'h1212_0012;
        for (int i = 0; i < 9; i++) begin
            wb_en = 1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            step();
        end
        chk("stall_after_9", wb_stall, GUARD);
        wb_en = !GUARD;
        step();
        if (md_gr) md_valid = 0;
        wb_en = 0;
        chk("stall_drop", wb_stall, 0);
        step();
        md_valid = 0;
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            step();
        end
        md_valid = 0; lsu_valid = 0; wb_en = 0; sb_set = 0;
        step();
        step();
        chk("drain", expq.size(), 0);

        // asynchronous reset during a blocked md handshake
        for (int r = 1; r < 32; r++) begin
            sb_set = 1; sb_rd = 5'(r);
            step();
        end
        wb_en = 1; wb_rd = 6; wb_data = 32'h6666_0006;
        md_valid = 1; md_rd = 11; md_data = 32'h1111_000B;
        sb_set = 1; sb_rd = 10; rs1_addr = 10; rs2_addr = 11;
        step();
        sb_set = 0;
        chk("pre_rst_busy", rs1_busy, 1);
        chk("pre_rst_wr", wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_busy1", rs1_busy, 0);
        chk("mid_rst_busy2", rs2_busy, 0);
        chk("mid_rst_stall", wb_stall, 0);
        chk("mid_rst_md_rdy", md_ready, 0);
        expq.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        wb_en = 0;
        step();
        md_valid = 0;
        step();
        step();
        chk("final_drain", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port arbiter and destination scoreboard for the BRV32P 32x32 register file. It shares the register file's single synchronous write port among three sources: the in-order pipeline writeback, the multi-cycle mul/div unit and the late-returning load path. It also tracks which destination registers have writes outstanding from the long-latency units, so the hazard unit can stall dependent instructions. It sits between the writeback stage / execution units and the regfile write port.

## Interface
- STARVE_LIMIT, 8: consecutive blocked cycles of a secondary requester before it forces a writeback bubble (range 1–255).
- clk  in  1  core clock.
- rst_n  in  1  asynchronous reset, active-low.
- wb_en  in  1  pipeline writeback valid; always granted, never backpressured.
- wb_rd  in  5  pipeline destination.
- wb_data  in  32  pipeline result.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  mul/div result accepted this cycle.
- md_rd  in  5  mul/div destination.
- md_data  in  32  mul/div result.
- lsu_valid  in  1  late load data valid.
- lsu_ready  out  1  late load data accepted this cycle.
- lsu_rd  in  5  load destination.
- lsu_data  in  32  load data.
- sb_set  in  1  issue marks a long-latency destination pending.
- sb_rd  in  5  destination to mark.
- rs1_addr  in  5  hazard query A.
- rs2_addr  in  5  hazard query B.
- rs1_busy  out  1  rs1_addr has a pending long-latency write.
- rs2_busy  out  1  rs2_addr has a pending long-latency write.
- wb_stall  out  1  requests that the pipeline withhold wb_en.
- wr_en  out  1  regfile write enable (registered).
- rd_addr  out  5  regfile write address (registered).
- rd_data  out  32  regfile write data (registered).

## Operation
- Arbitration is combinational each cycle; the winner is captured into the wr_* output register.
- Priority: wb_en beats everything. With wb_en=0, md and lsu share the slot round-robin.
- Round-robin pointer:
  - Selects the requester that was not granted most recently.
  - Updates only on a secondary grant.
  - Reset value favours md.
- md_ready = !wb_en && md selected. lsu_ready likewise.
  - Ready depends combinationally on valid and wb_en; a requester never waits on ready before asserting valid.
  - Requesters hold rd and data stable while valid && !ready.
- Writes to x0:
  - The handshake completes normally.
  - wr_en stays 0.
  - The scoreboard is untouched.
- Scoreboard is a 32-bit pending vector; bit 0 is never set.
  - sb_set sets bit sb_rd.
  - A granted md/lsu write clears bit rd.
  - If set and clear hit the same register in the same cycle, set wins.
  - The pipeline WB path never touches the scoreboard.
- rs1_busy and rs2_busy read the pending vector combinationally. x0 always reads 0.
- Starvation counters: one per secondary requester.
  - Increments while that requester is valid && !ready, saturating at STARVE_LIMIT.
  - Clears on grant or when valid drops.
- Configuration RF_ARB_STARVE_GUARD_EN (see Configuration) gates the starvation counters and wb_stall.

## Timing
- Reset values:
  - wr_en=0, rd_addr=0, rd_data=0.
  - Pending vector all 0; wb_stall=0; starvation counters 0.
  - md_ready=0 and lsu_ready=0 while their valids are 0.
- Latency: a grant in cycle N makes wr_en/rd_addr/rd_data valid in cycle N+1, and the regfile commits at the edge ending N+1.
- The pending bit clears at the edge ending N, so busy drops in N+1 while the data is still only on rd_data. The hazard unit forwards from rd_data in that cycle.
- sb_set in cycle N makes busy visible in N+1.
- wb_stall is registered. It asserts the cycle after a counter reaches STARVE_LIMIT and deasserts the cycle after the starved requester is granted.
- The pipeline keeps wb_en=0 while wb_stall=1. If wb_en arrives anyway, WB still wins (protocol error; the bench flags it).
- Reset asserted mid-operation: everything clears immediately and asynchronously. Any handshake in flight is lost, and the requester re-presents it after reset.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined: starvation counters and wb_stall are implemented as described above.
- Undefined: no counters, wb_stall tied 0. Secondary requesters may starve indefinitely under continuous writeback.

## Test plan
- wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, with md_valid=1 in the same cycle → md_ready=0; next cycle wr_en=1, rd_addr=5, rd_data=0xDEADBEEF.
- wb_en=0, md and lsu both valid (md_rd=3, lsu_rd=4) for 2 cycles → md granted first then lsu; writes to x3 then x4 on consecutive cycles.
- sb_set with sb_rd=7, then md write to x7 three cycles later → rs1_busy=1 (rs1_addr=7) from the cycle after set until the cycle after grant. The same-cycle set+clear case keeps busy=1.
- lsu_valid with lsu_rd=0 → lsu_ready=1, wr_en stays 0, rs1_busy for x0 stays 0.
- With RF_ARB_STARVE_GUARD_EN and STARVE_LIMIT=8: wb_en held 1 while md is valid → wb_stall=1 after 9 cycles; pipeline drops wb_en; md granted; wb_stall=0 on the following cycle.
- Reset asserted during md_valid && !ready with busy bits set → all outputs and busy bits 0 immediately.
